acq_uart_framer: RTL

- Downstream consumer of the acquisition BRAM stage.
- When samples are available, it strobes the acquisition read clock, waits for the BRAM read latency, and latches the three 16-bit regrouped words.
- It then emits one framed byte packet to the UART transmitter over a valid/ready byte handshake.
- One frame carries one 48-bit BRAM word (four 12-bit samples).

---
 rtl/acq_uart_framer.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/acq_uart_framer.sv
// acq_uart_framer
// Downstream consumer of the acquisition BRAM stage. Each frame reads one
// 48-bit BRAM word (four 12-bit samples regrouped into three 16-bit words):
// strobe rd_clk for RD_PULSE cycles, wait RD_LAT cycles for the read data to
// settle, latch {data_in_1, data_in_2, data_in_3}, then stream the packet
// SYNC_BYTE, d1[15:8], d1[7:0], d2[15:8], d2[7:0], d3[15:8], d3[7:0] to the
// UART transmitter over a valid/ready byte handshake.
//
// Build option: define ACQ_FRAMER_CHECKSUM_EN to append one checksum byte
// (XOR of the header and all six payload bytes), giving 8-byte frames.
// Without it the frame is 7 bytes and no checksum logic exists.
//
// rd_clk, tx_valid and tx_data are driven straight from flops that load from
// the next-state logic. That keeps rd_clk glitch-free (it acts as a clock
// edge upstream) while giving the same cycle timing as a state decode.
module acq_uart_framer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         RD_PULSE  = 2,
    parameter int         RD_LAT    = 3,
    parameter int         FRAME_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               bram_empty,
    output logic               rd_clk,
    input  logic [15:0]        data_in_1,
    input  logic [15:0]        data_in_2,
    input  logic [15:0]        data_in_3,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               busy,
    output logic [FRAME_W-1:0] frame_cnt
);

    // FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_LATCH = 3'd3;
    localparam logic [2:0] ST_HDR   = 3'd4;
    localparam logic [2:0] ST_DATA  = 3'd5;
`ifdef ACQ_FRAMER_CHECKSUM_EN
    localparam logic [2:0] ST_CSUM  = 3'd6;
`endif
    localparam logic [2:0] ST_DONE  = 3'd7;

    // Terminal counts for the strobe-high and read-latency phases. When
    // RD_LAT is 0 the WAIT state is skipped, so LAT_LAST is never used then.
    localparam logic [3:0] PULSE_LAST = 4'(RD_PULSE - 1);
    localparam logic [3:0] LAT_LAST   = 4'(RD_LAT - 1);

    // Index of the last payload byte (six bytes, 0..5)
    localparam logic [2:0] IDX_LAST = 3'd5;

    logic [2:0]         state_reg,     state_next;
    logic [3:0]         cnt_reg,       cnt_next;
    logic [2:0]         idx_reg,       idx_next;
    logic [47:0]        payload_reg,   payload_next;
    logic [FRAME_W-1:0] frame_cnt_reg, frame_cnt_next;

    logic               rd_clk_reg,    rd_clk_next;
    logic               tx_valid_reg,  tx_valid_next;
    logic [7:0]         tx_data_reg,   tx_data_next;

    // Payload split into bytes in transmit order (MSB of data_in_1 first)
    logic [7:0] payload_bytes [6];

    for (genvar gi = 0; gi < 6; gi++) begin : g_payload_bytes
        assign payload_bytes[gi] = payload_reg[47 - 8*gi -: 8];
    end

`ifdef ACQ_FRAMER_CHECKSUM_EN
    // Running XOR: header first, then each payload byte in order
    logic [7:0] csum_chain [7];
    logic [7:0] csum_byte;

    assign csum_chain[0] = SYNC_BYTE;
    for (genvar gi = 0; gi < 6; gi++) begin : g_csum_chain
        assign csum_chain[gi + 1] = csum_chain[gi] ^ payload_bytes[gi];
    end
    assign csum_byte = csum_chain[6];
`endif

    // Next-state logic: frame sequencing, phase counters, payload capture
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        idx_next       = idx_reg;
        payload_next   = payload_reg;
        frame_cnt_next = frame_cnt_reg;

        case (state_reg)
            ST_IDLE: begin
                // enable only gates starting a frame; once REQ is entered
                // the frame always completes so no strobed word is lost.
                if (enable && !bram_empty) begin
                    state_next = ST_REQ;
                    cnt_next   = '0;
                end
            end

            ST_REQ: begin
                if (cnt_reg == PULSE_LAST) begin
                    cnt_next   = '0;
                    state_next = (RD_LAT == 0) ? ST_LATCH : ST_WAIT;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            ST_WAIT: begin
                if (cnt_reg == LAT_LAST) begin
                    cnt_next   = '0;
                    state_next = ST_LATCH;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end

            ST_LATCH: begin
                payload_next = {data_in_1, data_in_2, data_in_3};
                state_next   = ST_HDR;
            end

            ST_HDR: begin
                // tx_valid is high throughout this state, so tx_ready alone
                // marks the transfer edge.
                if (tx_ready) begin
                    state_next = ST_DATA;
                    idx_next   = '0;
                end
            end

            ST_DATA: begin
                if (tx_ready) begin
                    if (idx_reg == IDX_LAST) begin
                        idx_next = '0;
`ifdef ACQ_FRAMER_CHECKSUM_EN
                        state_next = ST_CSUM;
`else
                        state_next = ST_DONE;
`endif
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end

`ifdef ACQ_FRAMER_CHECKSUM_EN
            ST_CSUM: begin
                if (tx_ready) begin
                    state_next = ST_DONE;
                end
            end
`endif

            ST_DONE: begin
                // Wraps silently at 2^FRAME_W
                frame_cnt_next = frame_cnt_reg + 1'b1;
                state_next     = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output pre-decode from the upcoming state so the output flops line up
    // with the state they describe.
    always_comb begin
        rd_clk_next   = (state_next == ST_REQ);
        tx_valid_next = 1'b0;
        tx_data_next  = '0;

        case (state_next)
            ST_HDR: begin
                tx_valid_next = 1'b1;
                tx_data_next  = SYNC_BYTE;
            end

            ST_DATA: begin
                // payload_reg is stable here: it only loads in LATCH,
                // which is always followed by HDR, never DATA.
                tx_valid_next = 1'b1;
                case (idx_next)
                    3'd0:    tx_data_next = payload_bytes[0];
                    3'd1:    tx_data_next = payload_bytes[1];
                    3'd2:    tx_data_next = payload_bytes[2];
                    3'd3:    tx_data_next = payload_bytes[3];
                    3'd4:    tx_data_next = payload_bytes[4];
                    default: tx_data_next = payload_bytes[5];
                endcase
            end

`ifdef ACQ_FRAMER_CHECKSUM_EN
            ST_CSUM: begin
                tx_valid_next = 1'b1;
                tx_data_next  = csum_byte;
            end
`endif

            default: begin
                tx_valid_next = 1'b0;
                tx_data_next  = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            idx_reg       <= '0;
            payload_reg   <= '0;
            frame_cnt_reg <= '0;
            rd_clk_reg    <= 1'b0;
            tx_valid_reg  <= 1'b0;
            tx_data_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            payload_reg   <= payload_next;
            frame_cnt_reg <= frame_cnt_next;
            rd_clk_reg    <= rd_clk_next;
            tx_valid_reg  <= tx_valid_next;
            tx_data_reg   <= tx_data_next;
        end
    end

    assign rd_clk    = rd_clk_reg;
    assign tx_valid  = tx_valid_reg;
    assign tx_data   = tx_data_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign frame_cnt = frame_cnt_reg;

endmodule
